// File: rtl/arbiter_wrr_n_to_1_scheduler_pkg.sv
// Shared types and constants for the weighted round-robin scheduler family.
package arbiter_wrr_n_to_1_scheduler_pkg;

    localparam int ARBITER_WRR_MAX_REQUESTOR = 16;
    localparam int ARBITER_WRR_MAX_WEIGHT_W  = 8;

    typedef logic [ARBITER_WRR_MAX_REQUESTOR-1:0][ARBITER_WRR_MAX_WEIGHT_W-1:0] ArbiterWeightConfig;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } ArbiterWRRState;

    // Index width that stays legal for a single requestor.
    function automatic int arbiter_wrr_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbiter_rr_next_select.sv
// Combinational first-set search starting at a pointer (inclusive) with wrap-around.
module arbiter_rr_next_select
    import arbiter_wrr_n_to_1_scheduler_pkg::*;
#(
    parameter int NUM_REQUESTOR = 4,
    parameter int IDX_W         = arbiter_wrr_idx_w(NUM_REQUESTOR)
) (
    input  logic [NUM_REQUESTOR-1:0] i_req,
    input  logic [IDX_W-1:0]         i_ptr,
    output logic [IDX_W-1:0]         o_idx,
    output logic                     o_found
);

    logic [NUM_REQUESTOR-1:0] w_rot;
    int                       w_sum;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        o_idx   = '0;
        o_found = 1'b0;
        w_sum   = 0;
        // Bit k of the rotated vector is requestor (ptr + k) mod N.
        w_rot   = NUM_REQUESTOR'({i_req, i_req} >> i_ptr);
        for (int k = 0; k < NUM_REQUESTOR; k++) begin
            if (!o_found && w_rot[k]) begin
                o_found = 1'b1;
                w_sum   = int'(i_ptr) + k;
                if (w_sum >= NUM_REQUESTOR) begin
                    w_sum = w_sum - NUM_REQUESTOR;
                end
                o_idx = IDX_W'(w_sum);
            end
        end
    end

endmodule

// File: rtl/arbiter_wrr_n_to_1_scheduler.sv
// Weighted round-robin N-to-1 scheduler with registered grant and payload mux.
// Optional per-requestor grant counters: define ARBITER_WRR_GRANT_STATS_EN.
module arbiter_wrr_n_to_1_scheduler
    import arbiter_wrr_n_to_1_scheduler_pkg::*;
#(
    parameter int NUM_REQUESTOR = 4,
    parameter int WEIGHT_W      = 4,
    parameter int BUS_WIDTH     = 64
) (
    input  logic                               ap_clk,
    input  logic                               areset,
    input  logic [NUM_REQUESTOR*WEIGHT_W-1:0]  config_weight_in,
    input  logic                               config_valid_in,
    input  logic [NUM_REQUESTOR-1:0]           arbiter_req_in,
    input  logic [NUM_REQUESTOR-1:0]           arbiter_bus_valid_in,
    input  logic [NUM_REQUESTOR*BUS_WIDTH-1:0] arbiter_bus_in,
    input  logic                               downstream_ready_in,
    output logic [NUM_REQUESTOR-1:0]           arbiter_grant_out,
    output logic [BUS_WIDTH-1:0]               arbiter_bus_out,
    output logic                               arbiter_bus_valid_out,
    output logic                               idle_out
`ifdef ARBITER_WRR_GRANT_STATS_EN
    ,
    output logic [NUM_REQUESTOR*32-1:0]        grant_count_out
`endif
);

    localparam int         IDX_W    = arbiter_wrr_idx_w(NUM_REQUESTOR);
    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_SERVE = 1'(SERVE);
    localparam logic [NUM_REQUESTOR-1:0][WEIGHT_W-1:0] WEIGHTS_ONE = {NUM_REQUESTOR{WEIGHT_W'(1)}};

    function automatic logic [WEIGHT_W-1:0] quantum(input logic [WEIGHT_W-1:0] weight);
        return (weight == '0) ? WEIGHT_W'(1) : weight;
    endfunction

    logic [0:0]                             r_state;
    logic [IDX_W-1:0]                       r_ptr;
    logic [IDX_W-1:0]                       r_sel;
    logic [IDX_W-1:0]                       r_grant_idx;
    logic [WEIGHT_W-1:0]                    r_credit;
    logic [NUM_REQUESTOR-1:0][WEIGHT_W-1:0] r_active_w;
    logic [NUM_REQUESTOR-1:0][WEIGHT_W-1:0] r_shadow_w;
    logic                                   r_cfg_pending;
    logic [NUM_REQUESTOR-1:0]               r_grant;
    logic [BUS_WIDTH-1:0]                   r_bus;
    logic                                   r_bus_valid;
    logic                                   r_idle;

    logic [NUM_REQUESTOR-1:0][WEIGHT_W-1:0]  w_eff_w;
    logic [NUM_REQUESTOR-1:0][BUS_WIDTH-1:0] w_bus_in;
    logic [IDX_W-1:0]                        w_next_idx;
    logic [IDX_W-1:0]                        w_ptr_after_sel;
    logic                                    w_found;
    logic                                    w_any_req;

    assign w_any_req       = |arbiter_req_in;
    assign w_bus_in        = arbiter_bus_in;
    // A pending configuration is applied in the same IDLE cycle that loads the credit.
    assign w_eff_w         = r_cfg_pending ? r_shadow_w : r_active_w;
    assign w_ptr_after_sel = (r_sel == IDX_W'(NUM_REQUESTOR - 1)) ? '0 : r_sel + IDX_W'(1);

    arbiter_rr_next_select #(
        .NUM_REQUESTOR (NUM_REQUESTOR),
        .IDX_W         (IDX_W)
    ) u_next_select (
        .i_req   (arbiter_req_in),
        .i_ptr   (r_ptr),
        .o_idx   (w_next_idx),
        .o_found (w_found)
    );

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_sel         <= '0;
            r_grant_idx   <= '0;
            r_credit      <= '0;
            r_active_w    <= WEIGHTS_ONE;
            r_shadow_w    <= WEIGHTS_ONE;
            r_cfg_pending <= 1'b0;
            r_grant       <= '0;
            r_idle        <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments throughout; later writes in this block take priority.
            r_grant <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (r_cfg_pending) begin
                        r_active_w    <= r_shadow_w;
                        r_cfg_pending <= 1'b0;
                    end
                    r_idle <= !w_any_req;
                    if (w_found) begin
                        r_sel    <= w_next_idx;
                        r_credit <= quantum(w_eff_w[w_next_idx]);
                        r_state  <= ST_SERVE;
                    end
                end
                default: begin
                    r_idle <= 1'b0;
                    // Back-pressure freezes the quantum entirely, including a dropped request.
                    if (downstream_ready_in) begin
                        if (arbiter_req_in[r_sel]) begin
                            r_grant[r_sel] <= 1'b1;
                            r_grant_idx    <= r_sel;
                            r_credit       <= r_credit - WEIGHT_W'(1);
                        end
                        if (!arbiter_req_in[r_sel] || (r_credit == WEIGHT_W'(1))) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= w_ptr_after_sel;
                            r_idle  <= !w_any_req;
                        end
                    end
                end
            endcase
            if (config_valid_in) begin
                r_shadow_w    <= config_weight_in;
                r_cfg_pending <= 1'b1;
            end
        end
    end

    // Payload follows the pop strobe by one cycle, matching first-word-fall-through timing.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            // NOTE: the data register is reset too, so the bus reads zero out of reset.
            r_bus       <= '0;
            r_bus_valid <= 1'b0;
        end else begin
            r_bus_valid <= 1'b0;
            if (|r_grant) begin
                r_bus       <= w_bus_in[r_grant_idx];
                r_bus_valid <= arbiter_bus_valid_in[r_grant_idx];
            end
        end
    end

    assign arbiter_grant_out     = r_grant;
    assign arbiter_bus_out       = r_bus;
    assign arbiter_bus_valid_out = r_bus_valid;
    assign idle_out              = r_idle;

`ifdef ARBITER_WRR_GRANT_STATS_EN
    logic [NUM_REQUESTOR-1:0][31:0] r_grant_count;

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            r_grant_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQUESTOR; i++) begin
                if (config_valid_in) begin
                    r_grant_count[i] <= '0;
                end else if (r_grant[i] && (r_grant_count[i] != '1)) begin
                    r_grant_count[i] <= r_grant_count[i] + 32'd1;
                end
            end
        end
    end

    assign grant_count_out = r_grant_count;
`endif

endmodule

// File: tb/tb_arbiter_wrr_n_to_1_scheduler.sv
// Self-checking bench: cycle-level behavioural model, directed scenarios and random traffic.
module tb_arbiter_wrr_n_to_1_scheduler;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int BW = 64;

    logic              ap_clk = 1'b0;
    logic              areset = 1'b1;
    logic [N*WW-1:0]   config_weight_in = '0;
    logic              config_valid_in = 1'b0;
    logic [N-1:0]      arbiter_req_in = '0;
    logic [N-1:0]      arbiter_bus_valid_in = '0;
    logic [N*BW-1:0]   arbiter_bus_in = '0;
    logic              downstream_ready_in = 1'b1;
    logic [N-1:0]      arbiter_grant_out;
    logic [BW-1:0]     arbiter_bus_out;
    logic              arbiter_bus_valid_out;
    logic              idle_out;
`ifdef ARBITER_WRR_GRANT_STATS_EN
    logic [N*32-1:0]   grant_count_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    arbiter_wrr_n_to_1_scheduler #(
        .NUM_REQUESTOR (N),
        .WEIGHT_W      (WW),
        .BUS_WIDTH     (BW)
    ) dut (
        .ap_clk                (ap_clk),
        .areset                (areset),
        .config_weight_in      (config_weight_in),
        .config_valid_in       (config_valid_in),
        .arbiter_req_in        (arbiter_req_in),
        .arbiter_bus_valid_in  (arbiter_bus_valid_in),
        .arbiter_bus_in        (arbiter_bus_in),
        .downstream_ready_in   (downstream_ready_in),
        .arbiter_grant_out     (arbiter_grant_out),
        .arbiter_bus_out       (arbiter_bus_out),
        .arbiter_bus_valid_out (arbiter_bus_valid_out),
        .idle_out              (idle_out)
`ifdef ARBITER_WRR_GRANT_STATS_EN
        ,
        .grant_count_out       (grant_count_out)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_serving;
    int            m_ptr, m_sel, m_credit;
    int            m_active [N];
    int            m_shadow [N];
    bit            m_pending;
    int            e_grant;
    bit            e_valid;
    logic [BW-1:0] e_bus;
    bit            e_idle;

    int cyc = 0;
    int grant_at [int];

    task automatic model_reset();
        m_serving = 1'b0;
        m_ptr     = 0;
        m_sel     = 0;
        m_credit  = 0;
        for (int i = 0; i < N; i++) begin
            m_active[i] = 1;
            m_shadow[i] = 1;
        end
        m_pending = 1'b0;
        e_grant   = -1;
        e_valid   = 1'b0;
        e_bus     = '0;
        e_idle    = 1'b1;
    endtask

    task automatic model_step();
        bit            any;
        bit            hit;
        int            ng;
        bit            n_valid;
        logic [BW-1:0] n_bus;
        bit            n_idle;
        any     = |arbiter_req_in;
        ng      = -1;
        n_valid = 1'b0;
        n_bus   = e_bus;
        n_idle  = 1'b0;
        if (e_grant >= 0) begin
            n_valid = arbiter_bus_valid_in[e_grant];
            n_bus   = arbiter_bus_in[e_grant*BW +: BW];
        end
        if (!m_serving) begin
            if (m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            n_idle = !any;
            if (any) begin
                hit = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!hit && arbiter_req_in[(m_ptr + k) % N]) begin
                        hit   = 1'b1;
                        m_sel = (m_ptr + k) % N;
                    end
                end
                m_credit  = (m_active[m_sel] == 0) ? 1 : m_active[m_sel];
                m_serving = 1'b1;
            end
        end else if (downstream_ready_in) begin
            if (arbiter_req_in[m_sel]) begin
                ng       = m_sel;
                m_credit = m_credit - 1;
            end
            if (!arbiter_req_in[m_sel] || m_credit == 0) begin
                m_serving = 1'b0;
                m_ptr     = (m_sel + 1) % N;
                n_idle    = !any;
            end
        end
        if (config_valid_in) begin
            for (int i = 0; i < N; i++) m_shadow[i] = int'(config_weight_in[i*WW +: WW]);
            m_pending = 1'b1;
        end
        e_grant = ng;
        e_valid = n_valid;
        e_bus   = n_bus;
        e_idle  = n_idle;
    endtask

    // Compare on the falling edge, then advance the model with the inputs the DUT will see.
    always @(negedge ap_clk) begin
        cyc++;
        if (areset) model_reset();
        check("grant", 64'(arbiter_grant_out), (e_grant >= 0) ? (64'(1) << e_grant) : 64'(0));
        check("bus_valid", 64'(arbiter_bus_valid_out), 64'(e_valid));
        if (e_valid) check("bus_data", arbiter_bus_out, e_bus);
        check("idle", 64'(idle_out), 64'(e_idle));
        grant_at[cyc] = e_grant;
        if (!areset) model_step();
    end

    // ---------------- stimulus helpers ----------------
    int g_idx [$];
    int g_cyc [$];
    int runs  [$];

    task automatic tick();
        @(posedge ap_clk);
        #1;
        for (int w = 0; w < N*BW/32; w++) arbiter_bus_in[w*32 +: 32] = $urandom;
        arbiter_bus_valid_in = N'($urandom);
        config_valid_in      = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        arbiter_req_in      = '0;
        downstream_ready_in = 1'b1;
        areset              = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic cfg(input logic [N*WW-1:0] w);
        config_weight_in = w;
        config_valid_in  = 1'b1;
    endtask

    task automatic wait_grant(input int idx);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            if (arbiter_grant_out[idx]) ok = 1'b1;
        end
        check("wait_grant_timeout", 64'(ok), 64'(1));
    endtask

    task automatic collect(input int from, input int to);
        g_idx.delete();
        g_cyc.delete();
        for (int c = from; c <= to; c++) begin
            if (grant_at.exists(c) && grant_at[c] >= 0) begin
                g_idx.push_back(grant_at[c]);
                g_cyc.push_back(c);
            end
        end
    endtask

    task automatic make_runs();
        int last;
        runs.delete();
        foreach (g_cyc[k]) begin
            if (k > 0 && g_cyc[k] == g_cyc[k-1] + 1) begin
                last       = runs.size() - 1;
                runs[last] = runs[last] + 1;
            end else begin
                runs.push_back(1);
            end
        end
    endtask

    int seq1 [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    int off1 [10] = '{0, 2, 3, 5, 6, 7, 9, 10, 11, 12};
    int run4 [3]  = '{4, 2, 2};

    initial begin
        int t0, tg, c1, c2, c3, cnt;

        // Test 1: weights {1,2,3,4}, everyone requesting.
        do_reset();
        check("reset_grant", 64'(arbiter_grant_out), 64'(0));
        check("reset_idle", 64'(idle_out), 64'(1));
        check("reset_bus", arbiter_bus_out, 64'(0));
        cfg(16'h4321);
        tick();
        tick();
        arbiter_req_in = 4'hF;
        t0 = cyc + 1;
        repeat (20) tick();
        arbiter_req_in = '0;
        repeat (4) tick();
        collect(t0, t0 + 20);
        check("t1_count", 64'(g_idx.size() >= 10), 64'(1));
        if (g_cyc.size() > 0) check("t1_latency", 64'(g_cyc[0] - t0), 64'(2));
        for (int k = 0; k < 10 && k < g_idx.size(); k++) begin
            check("t1_seq", 64'(g_idx[k]), 64'(seq1[k]));
            check("t1_offset", 64'(g_cyc[k] - g_cyc[0]), 64'(off1[k]));
        end

        // Test 2: requestor 0 (weight 3) empties after one grant.
        do_reset();
        cfg(16'h1113);
        tick();
        tick();
        arbiter_req_in = 4'b0101;
        wait_grant(0);
        arbiter_req_in[0] = 1'b0;
        tg = cyc + 1;
        repeat (10) tick();
        arbiter_req_in = '0;
        repeat (4) tick();
        collect(tg, tg + 10);
        check("t2_count", 64'(g_idx.size() >= 2), 64'(1));
        if (g_idx.size() >= 2) begin
            check("t2_first", 64'(g_idx[0]), 64'(0));
            check("t2_next", 64'(g_idx[1]), 64'(2));
            check("t2_next_cycle", 64'(g_cyc[1] - tg), 64'(3));
        end

        // Test 3: 5-cycle stall after two grants of a weight-4 quantum.
        do_reset();
        cfg(16'h1141);
        tick();
        tick();
        arbiter_req_in = 4'b0010;
        wait_grant(1);
        wait_grant(1);
        downstream_ready_in = 1'b0;
        tg = cyc + 1;
        repeat (5) tick();
        downstream_ready_in = 1'b1;
        repeat (6) tick();
        arbiter_req_in = '0;
        repeat (4) tick();
        collect(tg + 1, tg + 5);
        check("t3_stall_grants", 64'(g_idx.size()), 64'(0));
        collect(tg + 6, tg + 8);
        check("t3_resume_grants", 64'(g_idx.size()), 64'(2));

        // Test 4: reconfiguration mid-quantum takes effect on the next quantum.
        do_reset();
        cfg(16'h4444);
        tick();
        tick();
        arbiter_req_in = 4'b0001;
        wait_grant(0);
        cfg(16'h2222);
        tg = cyc + 1;
        repeat (20) tick();
        arbiter_req_in = '0;
        repeat (4) tick();
        collect(tg, tg + 20);
        make_runs();
        check("t4_runs", 64'(runs.size() >= 3), 64'(1));
        for (int k = 0; k < 3 && k < runs.size(); k++) check("t4_run_len", 64'(runs[k]), 64'(run4[k]));

        // Test 5: weight 0 on requestor 3, then pointer wrap to 0.
        do_reset();
        cfg(16'h0111);
        tick();
        tick();
        arbiter_req_in = 4'b1000;
        wait_grant(3);
        c1 = cyc + 1;
        wait_grant(3);
        c2 = cyc + 1;
        wait_grant(3);
        c3 = cyc + 1;
        check("t5_period_a", 64'(c2 - c1), 64'(2));
        check("t5_period_b", 64'(c3 - c2), 64'(2));
        arbiter_req_in = 4'b1001;
        repeat (8) tick();
        arbiter_req_in = '0;
        repeat (4) tick();
        collect(c3 + 1, c3 + 8);
        check("t5_count", 64'(g_idx.size() >= 2), 64'(1));
        if (g_idx.size() >= 2) begin
            check("t5_wrap_first", 64'(g_idx[0]), 64'(0));
            check("t5_wrap_cycle", 64'(g_cyc[0] - c3), 64'(2));
            check("t5_wrap_second", 64'(g_idx[1]), 64'(3));
        end

        // Test 6: asynchronous reset while a grant is high.
        do_reset();
        arbiter_req_in = 4'b1010;
        wait_grant(3);
        areset = 1'b1;
        #1;
        check("t6_grant_cleared", 64'(arbiter_grant_out), 64'(0));
        check("t6_valid_cleared", 64'(arbiter_bus_valid_out), 64'(0));
        check("t6_idle_set", 64'(idle_out), 64'(1));
        tick();
        areset = 1'b0;
        tg = cyc + 1;
        repeat (6) tick();
        arbiter_req_in = '0;
        repeat (4) tick();
        collect(tg, tg + 6);
        check("t6_count", 64'(g_idx.size() >= 1), 64'(1));
        if (g_idx.size() >= 1) begin
            check("t6_first", 64'(g_idx[0]), 64'(1));
            check("t6_first_cycle", 64'(g_cyc[0] - tg), 64'(2));
        end

        // Random traffic against the model.
        do_reset();
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(7) == 0) arbiter_req_in[r] = ~arbiter_req_in[r];
            end
            downstream_ready_in = ($urandom_range(3) != 0);
            if ($urandom_range(39) == 0) cfg(N*WW'($urandom));
            if (areset) begin
                areset = 1'b0;
            end else if ($urandom_range(699) == 0) begin
                areset = 1'b1;
                cnt++;
            end
        end
        areset         = 1'b0;
        arbiter_req_in = '0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbiter_wrr_n_to_1_scheduler.md
Name: arbiter_wrr_N_to_1_scheduler

Overview:
Weighted round-robin (WRR) scheduler for N engine requestors sharing one downstream engine-packet bus and FIFO.
- Each requestor gets a programmable burst quantum of consecutive grants per turn.
- Grants are gated by downstream back-pressure.
- Registered payload mux drives the shared bus.
- Drop-in replacement for the plain round-robin bus arbiter in front of the request/response FIFOs.

Parameters:
NUM_REQUESTOR, 4, number of requestors (1..16).
WEIGHT_W, 4, width of each per-requestor weight (quantum = weight, 0 treated as 1).
BUS_WIDTH, 64, width of the muxed payload bus.

Ports:
ap_clk  in  1  clock.
areset  in  1  reset; one clock, reset is asynchronous and active-high.
config_weight_in  in  NUM_REQUESTOR*WEIGHT_W  packed weights, requestor i at [i*WEIGHT_W +: WEIGHT_W].
config_valid_in  in  1  one-cycle strobe capturing config_weight_in into the shadow register.
arbiter_req_in  in  NUM_REQUESTOR  per-requestor request (source FIFO not empty).
arbiter_bus_valid_in  in  NUM_REQUESTOR  per-requestor payload valid.
arbiter_bus_in  in  NUM_REQUESTOR*BUS_WIDTH  packed payloads.
downstream_ready_in  in  1  downstream can accept (~prog_full).
arbiter_grant_out  out  NUM_REQUESTOR  one-hot registered grant (pop strobe).
arbiter_bus_out  out  BUS_WIDTH  registered selected payload.
arbiter_bus_valid_out  out  1  registered valid for arbiter_bus_out.
idle_out  out  1  FSM in IDLE and no request pending.

Behaviour:
Reset (async assert, sync deassert):
- arbiter_grant_out=0, arbiter_bus_valid_out=0, arbiter_bus_out=0, idle_out=1.
- Pointer=0, credit=0, active weights = all 1, shadow weights = all 1, config_pending=0.

FSM states:
- IDLE:
  - If config_pending, copy shadow to active weights, clear config_pending.
  - If |arbiter_req_in, select first requesting index searching from pointer (inclusive, wrapping), load credit=max(weight[sel],1), go to SERVE.
- SERVE:
  - If downstream_ready_in & arbiter_req_in[sel]: assert arbiter_grant_out[sel] for this cycle and decrement credit.
  - If credit reaches 0 or req[sel] drops: pointer=sel+1 mod NUM_REQUESTOR, go to IDLE.
  - If downstream_ready_in=0: grant=0, credit and state held.

Timing and data path:
- Grant latency: request visible at cycle t in IDLE, first grant at t+2 (select cycle, then registered grant).
- Payload: arbiter_bus_out/arbiter_bus_valid_out register arbiter_bus_in[g]/arbiter_bus_valid_in[g] of the index granted in the previous cycle (1-cycle latency after grant, matching FWFT pop timing). Valid is 0 when no grant was issued the previous cycle.
- At most one grant bit high per cycle; never to a requestor whose req is low.

Configuration:
- config_valid_in in any state latches the shadow register and sets config_pending; applied only on IDLE entry, so an in-progress quantum is never altered.
- A second strobe before application overwrites the shadow.

Boundary conditions:
- Weight 0 is treated as 1.
- Single requestor continuously requesting: served in back-to-back quanta, passing through IDLE for one bubble cycle between quanta.
- Pointer wraps from NUM_REQUESTOR-1 to 0.
- Reset mid-SERVE: grant and valid cleared immediately, no partial quantum is remembered.

Optional Feature:
ARBITER_WRR_GRANT_STATS_EN
- Defined: adds output grant_count_out (NUM_REQUESTOR*32), one saturating 32-bit counter per requestor, incremented on each grant. Cleared by reset and by config_valid_in.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
Shared package holds:
- typedef ArbiterWeightConfig (packed weight array).
- enum ArbiterWRRState {IDLE, SERVE}.
- Constant ARBITER_WRR_MAX_REQUESTOR=16.

One sub-module: arbiter_rr_next_select. Combinational first-set search from a pointer with wrap. Outputs index and found flag; reused by other arbiters.

Test Plan:
- Weights {1,2,3,4}, all 4 requesting, ready=1: grant sequence 0,1,1,2,2,2,3,3,3,3 with an IDLE bubble between quanta; bus_out matches granted payload one cycle later.
- Weight 3 for req 0, req0 drops after 1 grant while req2 is high: pointer moves to 1, next grant goes to req 2.
- downstream_ready_in low for 5 cycles mid-quantum (weight 4, 2 grants used): no grants during the stall, then exactly 2 more grants.
- config_valid_in with weights all 2 during SERVE of weight-4 quantum: current quantum still gives 4 grants, next quanta give 2.
- Weight 0 on req 3 alone requesting: 1 grant per quantum; pointer wraps to 0.
- areset pulsed while a grant is high: grant_out=0, bus_valid_out=0, idle_out=1 immediately; after release, first grant goes to lowest requesting index.
